// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer and its single-step shifter.
package shift_sequencer_pkg;

    localparam int SHIFT_WIDTH = 16;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ROL = 2'b10,
        SH_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step combinational shifter: one-bit logical shift or rotate per evaluation.
module shifter
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    input  shift_op_t        sel,
    input  logic             il,
    input  logic             ir,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = word;
        case (sel)
            SH_LSL:  result = {word[WIDTH-2:0], il};
            SH_LSR:  result = {ir, word[WIDTH-1:1]};
            SH_ROL:  result = {word[WIDTH-2:0], word[WIDTH-1]};
            SH_ROR:  result = {word[0], word[WIDTH-1:1]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller iterating the 1-bit shifter AMT times.
// Build option: SHIFT_SEQ_CARRY_EN adds a CARRY output holding the last bit shifted out.
//
// state  | meaning
// S_IDLE | waiting for START, result held on dout
// S_RUN  | one shifter step per clock, count tracks steps left
// S_FIN  | done pulse cycle, START ignored
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             fill,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
`ifdef SHIFT_SEQ_CARRY_EN
    output logic             carry,
`endif
    output logic             done
);

    if (WIDTH != SHIFT_WIDTH) begin : g_width_check
        $error("shift_sequencer: WIDTH must be 16 to match the shifter datapath");
    end

    seq_state_t       state;
    logic [AMT_W-1:0] count;
    shift_op_t        op_q;
    logic             fill_q;
    logic [WIDTH-1:0] stepped;

    shifter #(.WIDTH(WIDTH)) u_shifter (
        .word   (dout),
        .sel    (op_q),
        .il     (fill_q),
        .ir     (fill_q),
        .result (stepped)
    );

`ifdef SHIFT_SEQ_CARRY_EN
    // Left-moving ops lose the MSB, right-moving ops lose the LSB.
    logic out_bit;
    assign out_bit = op_q[0] ? dout[0] : dout[WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            dout   <= '0;
            count  <= '0;
            op_q   <= SH_LSL;
            fill_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
            carry  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dout   <= din;
                        count  <= amt;
                        op_q   <= shift_op_t'(op);
                        fill_q <= fill;
                        busy   <= 1'b1;
`ifdef SHIFT_SEQ_CARRY_EN
                        carry  <= 1'b0;
`endif
                        if (amt != '0) begin
                            state <= S_RUN;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dout  <= stepped;
                        count <= count - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
                        carry <= out_bit;
`endif
                        if (count == AMT_W'(1)) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (default build and SHIFT_SEQ_CARRY_EN build).
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [3:0]  amt = 4'd0;
    logic        fill = 1'b0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        busy;
    logic        done;
`ifdef SHIFT_SEQ_CARRY_EN
    logic        carry;
`endif

    int checks = 0;
    int failures = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .op    (op),
        .amt   (amt),
        .fill  (fill),
        .din   (din),
        .dout  (dout),
        .busy  (busy),
`ifdef SHIFT_SEQ_CARRY_EN
        .carry (carry),
`endif
        .done  (done)
    );

    always #5 clk = ~clk;

    // Present a command for one accept edge, then scramble inputs to prove they were latched.
    task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic f, input logic [15:0] d);
        @(negedge clk);
        op = o; amt = a; fill = f; din = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o; amt = ~a; fill = ~f; din = ~d;
    endtask

    // Issue a command and observe 20 cycles: index of first DONE, busy and done cycle counts.
    task automatic run_cmd(input logic [1:0] o, input logic [3:0] a, input logic f, input logic [15:0] d,
                           output int done_idx, output int busy_cnt, output int done_cnt);
        done_idx = -1; busy_cnt = 0; done_cnt = 0;
        issue(o, a, f, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lsl;
        int di, bc, dc;
        run_cmd(2'b00, 4'd4, 1'b1, 16'h8001, di, bc, dc);
        checks++; if (dout !== 16'h001F) begin failures++; $display("FAIL lsl_dout got=%h exp=001f", dout); end
        checks++; if (di !== 4) begin failures++; $display("FAIL lsl_done_idx got=%0d exp=4", di); end
        checks++; if (bc !== 5) begin failures++; $display("FAIL lsl_busy_cycles got=%0d exp=5", bc); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL lsl_done_cycles got=%0d exp=1", dc); end
    endtask

    task automatic test_lsr;
        int di, bc, dc;
        run_cmd(2'b01, 4'd3, 1'b1, 16'h8001, di, bc, dc);
        checks++; if (dout !== 16'hF000) begin failures++; $display("FAIL lsr_fill1_dout got=%h exp=f000", dout); end
        checks++; if (di !== 3) begin failures++; $display("FAIL lsr_done_idx got=%0d exp=3", di); end
        run_cmd(2'b01, 4'd3, 1'b0, 16'h8001, di, bc, dc);
        checks++; if (dout !== 16'h1000) begin failures++; $display("FAIL lsr_fill0_dout got=%h exp=1000", dout); end
    endtask

    task automatic test_rotate;
        int di, bc, dc;
        run_cmd(2'b11, 4'd4, 1'b0, 16'h1234, di, bc, dc);
        checks++; if (dout !== 16'h4123) begin failures++; $display("FAIL ror_dout got=%h exp=4123", dout); end
        run_cmd(2'b10, 4'd15, 1'b1, 16'h8001, di, bc, dc);
        checks++; if (dout !== 16'hC000) begin failures++; $display("FAIL rol15_dout got=%h exp=c000", dout); end
        checks++; if (di !== 15) begin failures++; $display("FAIL rol15_done_idx got=%0d exp=15", di); end
        checks++; if (bc !== 16) begin failures++; $display("FAIL rol15_busy_cycles got=%0d exp=16", bc); end
    endtask

    task automatic test_amt_zero;
        issue(2'b00, 4'd0, 1'b0, 16'hBEEF);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL amt0_done got=%b exp=1", done); end
        checks++; if (dout !== 16'hBEEF) begin failures++; $display("FAIL amt0_dout got=%h exp=beef", dout); end
        // START held during FIN must be ignored
        start = 1'b1; din = 16'h1111; amt = 4'd2; op = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fin_start_busy got=%b exp=0", busy); end
        checks++; if (dout !== 16'hBEEF) begin failures++; $display("FAIL fin_start_dout got=%h exp=beef", dout); end
    endtask

    task automatic test_back_to_back;
        int dc;
        dc = 0;
        issue(2'b00, 4'd5, 1'b0, 16'h1234);
        @(negedge clk);
        start = 1'b1; din = 16'hFFFF; amt = 4'd0; op = 2'b01; fill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checks++; if (dout !== 16'h4680) begin failures++; $display("FAIL busy_start_dout got=%h exp=4680", dout); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL busy_start_done_cycles got=%0d exp=1", dc); end
        checks++; if (dout !== 16'h4680) begin failures++; $display("FAIL idle_hold_dout got=%h exp=4680", dout); end
    endtask

    task automatic test_abort;
        int dc;
        dc = 0;
        issue(2'b00, 4'd8, 1'b0, 16'h0001);
        @(posedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checks++; if (dout !== 16'h0004) begin failures++; $display("FAIL abort_dout got=%h exp=0004", dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (dc !== 0) begin failures++; $display("FAIL abort_done_cycles got=%0d exp=0", dc); end
    endtask

    task automatic test_reset_mid_run;
        int dc;
        dc = 0;
        issue(2'b10, 4'd8, 1'b0, 16'hA5A5);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL midrst_dout got=%h exp=0000", dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checks++; if (dc !== 0) begin failures++; $display("FAIL midrst_done_cycles got=%0d exp=0", dc); end
    endtask

`ifdef SHIFT_SEQ_CARRY_EN
    task automatic test_carry;
        int di, bc, dc;
        run_cmd(2'b00, 4'd1, 1'b0, 16'h8001, di, bc, dc);
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL carry_lsl got=%b exp=1", carry); end
        checks++; if (dout !== 16'h0002) begin failures++; $display("FAIL carry_lsl_dout got=%h exp=0002", dout); end
        run_cmd(2'b00, 4'd0, 1'b0, 16'h8001, di, bc, dc);
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL carry_amt0 got=%b exp=0", carry); end
        run_cmd(2'b01, 4'd1, 1'b0, 16'h0003, di, bc, dc);
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL carry_lsr1 got=%b exp=1", carry); end
        run_cmd(2'b01, 4'd1, 1'b0, 16'h0002, di, bc, dc);
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL carry_lsr0 got=%b exp=0", carry); end
        checks++; if (dout !== 16'h0001) begin failures++; $display("FAIL carry_lsr0_dout got=%h exp=0001", dout); end
        run_cmd(2'b11, 4'd2, 1'b0, 16'h0002, di, bc, dc);
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL carry_ror got=%b exp=1", carry); end
    endtask
`endif

    initial begin
        test_reset();
        test_lsl();
        test_lsr();
        test_rotate();
        test_amt_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
`ifdef SHIFT_SEQ_CARRY_EN
        test_carry();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
